// File: rtl/image_cropping_pkg.sv
// Shared types and geometry for the image crop engine.
// CROP_INVERT_EN flips the foreground test to dark-on-light (pixel < THRESH).
package image_cropping_pkg;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int PIX_W  = 8;
    localparam int THRESH = 128;

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int AW    = $clog2(N_PIX);

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [XW-1:0]    xcoord_t;
    typedef logic [YW-1:0]    ycoord_t;
    typedef logic [XW:0]      wsize_t;
    typedef logic [YW:0]      hsize_t;
    typedef logic [AW-1:0]    addr_t;

    typedef enum logic [2:0] {
        SCAN_INIT,
        SCAN,
        SCAN_END,
        COPY,
        DONE
    } state_t;

    function automatic logic is_fg(pixel_t p);
`ifdef CROP_INVERT_EN
        return p < pixel_t'(THRESH);
`else
        return p > pixel_t'(THRESH);
`endif
    endfunction

endpackage

// File: rtl/image_cropping_if.sv
// Result bundle of the crop engine: completion flags and bounding-box geometry.
interface image_cropping_if
    import image_cropping_pkg::*;
;
    logic    done;
    logic    empty;
    xcoord_t x_min;
    xcoord_t x_max;
    ycoord_t y_min;
    ycoord_t y_max;
    wsize_t  crop_w;
    hsize_t  crop_h;

    modport master (output done, empty, x_min, x_max, y_min, y_max, crop_w, crop_h);
    modport slave  (input  done, empty, x_min, x_max, y_min, y_max, crop_w, crop_h);
endinterface

// File: rtl/image_cropping_bbox_tracker.sv
// Running min/max of foreground pixel coordinates; clear_i restarts the search.
module bbox_tracker
    import image_cropping_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clear_i,
    input  logic    vld_i,
    input  pixel_t  pix_i,
    input  xcoord_t x_i,
    input  ycoord_t y_i,
    output xcoord_t x_min_o,
    output xcoord_t x_max_o,
    output ycoord_t y_min_o,
    output ycoord_t y_max_o,
    output logic    found_o
);
    xcoord_t x_min_q, x_max_q;
    ycoord_t y_min_q, y_max_q;
    logic    found_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            found_q <= 1'b0;
        end else if (vld_i && is_fg(pix_i)) begin
            if (x_i < x_min_q) x_min_q <= x_i;
            if (x_i > x_max_q) x_max_q <= x_i;
            if (y_i < y_min_q) y_min_q <= y_i;
            if (y_i > y_max_q) y_max_q <= y_i;
            found_q <= 1'b1;
        end
    end

    assign x_min_o = x_min_q;
    assign x_max_o = x_max_q;
    assign y_min_o = y_min_q;
    assign y_max_o = y_max_q;
    assign found_o = found_q;
endmodule

// File: rtl/image_cropping.sv
// Self-starting crop engine: scans ram for the foreground bounding box, then copies
// the box row-major into crop_ram and raises done. Optional macro: CROP_INVERT_EN.
module image_cropping
    import image_cropping_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic [3:0]       KEY,
    image_cropping_if.master res
);
    localparam xcoord_t X_LAST = xcoord_t'(IMG_W - 1);
    localparam ycoord_t Y_LAST = ycoord_t'(IMG_H - 1);

    logic rst_n;
    logic unused_key;
    assign rst_n      = KEY[3];
    assign unused_key = ^KEY[2:0];

    pixel_t ram      [N_PIX];
    pixel_t crop_ram [N_PIX];

    state_t  state_q;
    xcoord_t x_q, px_q;
    ycoord_t y_q, py_q;
    logic    flush_q, rd_vld_q;
    addr_t   rd_addr_d, wr_q;
    pixel_t  ram_q;
    logic    done_q, empty_q;
    xcoord_t x_min_q, x_max_q;
    ycoord_t y_min_q, y_max_q;
    wsize_t  crop_w_q;
    hsize_t  crop_h_q;

    xcoord_t bb_x_min, bb_x_max;
    ycoord_t bb_y_min, bb_y_max;
    logic    bb_found;

    bbox_tracker u_bbox (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .clear_i (state_q == SCAN_INIT),
        .vld_i   (rd_vld_q && state_q == SCAN),
        .pix_i   (ram_q),
        .x_i     (px_q),
        .y_i     (py_q),
        .x_min_o (bb_x_min),
        .x_max_o (bb_x_max),
        .y_min_o (bb_y_min),
        .y_max_o (bb_y_max),
        .found_o (bb_found)
    );

    // x_q/y_q are absolute during SCAN and box-relative during COPY.
    always_comb begin
        rd_addr_d = addr_t'(int'(y_q) * IMG_W + int'(x_q));
        if (state_q == COPY)
            rd_addr_d = addr_t'((int'(y_min_q) + int'(y_q)) * IMG_W + int'(x_min_q) + int'(x_q));
    end

    // NOTE: memories carry no reset; only the control that qualifies their writes is reset.
    always_ff @(posedge CLOCK_50) begin
        ram_q <= ram[rd_addr_d];
        if (rst_n && state_q == COPY && rd_vld_q)
            crop_ram[wr_q] <= ram_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q  <= SCAN_INIT;
            x_q      <= '0;
            y_q      <= '0;
            px_q     <= '0;
            py_q     <= '0;
            flush_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            wr_q     <= '0;
            done_q   <= 1'b0;
            empty_q  <= 1'b0;
            x_min_q  <= '0;
            x_max_q  <= '0;
            y_min_q  <= '0;
            y_max_q  <= '0;
            crop_w_q <= '0;
            crop_h_q <= '0;
        end else begin
            px_q     <= x_q;
            py_q     <= y_q;
            rd_vld_q <= 1'b0;
            if (state_q == COPY && rd_vld_q) wr_q <= wr_q + addr_t'(1);
            unique case (state_q)
                SCAN_INIT: begin
                    x_q     <= '0;
                    y_q     <= '0;
                    flush_q <= 1'b0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    if (flush_q) begin
                        state_q <= SCAN_END;
                    end else begin
                        rd_vld_q <= 1'b1;
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            if (y_q == Y_LAST) flush_q <= 1'b1;
                            else               y_q     <= y_q + ycoord_t'(1);
                        end else begin
                            x_q <= x_q + xcoord_t'(1);
                        end
                    end
                end
                SCAN_END: begin
                    x_q     <= '0;
                    y_q     <= '0;
                    wr_q    <= '0;
                    flush_q <= 1'b0;
                    if (!bb_found) begin
                        empty_q  <= 1'b1;
                        done_q   <= 1'b1;
                        x_min_q  <= '0;
                        x_max_q  <= '0;
                        y_min_q  <= '0;
                        y_max_q  <= '0;
                        crop_w_q <= '0;
                        crop_h_q <= '0;
                        state_q  <= DONE;
                    end else begin
                        x_min_q  <= bb_x_min;
                        x_max_q  <= bb_x_max;
                        y_min_q  <= bb_y_min;
                        y_max_q  <= bb_y_max;
                        crop_w_q <= wsize_t'({1'b0, bb_x_max} - {1'b0, bb_x_min}) + wsize_t'(1);
                        crop_h_q <= hsize_t'({1'b0, bb_y_max} - {1'b0, bb_y_min}) + hsize_t'(1);
                        state_q  <= COPY;
                    end
                end
                COPY: begin
                    if (flush_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rd_vld_q <= 1'b1;
                        if ({1'b0, x_q} == crop_w_q - wsize_t'(1)) begin
                            x_q <= '0;
                            if ({1'b0, y_q} == crop_h_q - hsize_t'(1)) flush_q <= 1'b1;
                            else                                        y_q     <= y_q + ycoord_t'(1);
                        end else begin
                            x_q <= x_q + xcoord_t'(1);
                        end
                    end
                end
                DONE:    done_q  <= 1'b1;
                default: state_q <= SCAN_INIT;
            endcase
        end
    end

    assign res.done   = done_q;
    assign res.empty  = empty_q;
    assign res.x_min  = x_min_q;
    assign res.x_max  = x_max_q;
    assign res.y_min  = y_min_q;
    assign res.y_max  = y_max_q;
    assign res.crop_w = crop_w_q;
    assign res.crop_h = crop_h_q;
endmodule

// File: tb/tb_image_cropping.sv
// Scoreboard bench for image_cropping: frames are preloaded into dut.ram, a reference
// model predicts box, sizes, latency and crop contents; a monitor checks each done.
module tb_image_cropping;
    import image_cropping_pkg::*;

    typedef struct {
        bit empty;
        int x0, x1, y0, y1, w, h;
    } exp_t;

`ifdef CROP_INVERT_EN
    localparam int BG = 255, FG_A = 55, FG_B = 0, EDGE_YES = THRESH - 1;
`else
    localparam int BG = 0, FG_A = 200, FG_B = 255, EDGE_YES = THRESH + 1;
`endif
    localparam int EDGE_NO    = THRESH;
    localparam int RUN_BUDGET = 2 * N_PIX + 200;

    logic       clk;
    logic [3:0] key;

    image_cropping_if res ();
    image_cropping dut (.CLOCK_50(clk), .KEY(key), .res(res));

    int   frame      [N_PIX];
    int   crop_model [N_PIX];
    bit   crop_known [N_PIX];
    exp_t exp_q [$];

    int   n_checks = 0, n_err = 0, runs_checked = 0, cycle = 0, rel_cycle = 0;
    logic done_prev = 1'b0;
    exp_t mon_e;
    int   mon_bad, mon_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit fg(int p);
`ifdef CROP_INVERT_EN
        return p < THRESH;
`else
        return p > THRESH;
`endif
    endfunction

    function automatic int bg_val();
`ifdef CROP_INVERT_EN
        return int'($urandom_range(255, THRESH));
`else
        return int'($urandom_range(THRESH, 0));
`endif
    endfunction

    function automatic int fg_val();
`ifdef CROP_INVERT_EN
        return int'($urandom_range(THRESH - 1, 0));
`else
        return int'($urandom_range(255, THRESH + 1));
`endif
    endfunction

    // Reference: collect every foreground coordinate, take extremes, then cut the box out.
    task automatic model_run(output exp_t e);
        int xs[$], ys[$];
        for (int i = 0; i < N_PIX; i++)
            if (fg(frame[i])) begin
                xs.push_back(i % IMG_W);
                ys.push_back(i / IMG_W);
            end
        e = '{empty: 1'b1, x0: 0, x1: 0, y0: 0, y1: 0, w: 0, h: 0};
        if (xs.size() != 0) begin
            e.empty = 1'b0;
            e.x0 = IMG_W; e.x1 = -1; e.y0 = IMG_H; e.y1 = -1;
            for (int k = 0; k < xs.size(); k++) begin
                if (xs[k] < e.x0) e.x0 = xs[k];
                if (xs[k] > e.x1) e.x1 = xs[k];
                if (ys[k] < e.y0) e.y0 = ys[k];
                if (ys[k] > e.y1) e.y1 = ys[k];
            end
            e.w = e.x1 - e.x0 + 1;
            e.h = e.y1 - e.y0 + 1;
            for (int r = 0; r < e.h; r++)
                for (int c = 0; c < e.w; c++) begin
                    crop_model[r * e.w + c] = frame[(e.y0 + r) * IMG_W + e.x0 + c];
                    crop_known[r * e.w + c] = 1'b1;
                end
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N_PIX; i++) frame[i] = v;
    endtask

    task automatic gen_random();
        int bw, bh, bx, by, n;
        for (int i = 0; i < N_PIX; i++) frame[i] = bg_val();
        bw = int'($urandom_range(16, 1));
        bh = int'($urandom_range(16, 1));
        bx = int'($urandom_range(IMG_W - bw, 0));
        by = int'($urandom_range(IMG_H - bh, 0));
        n  = int'($urandom_range(6, 1));
        for (int k = 0; k < n; k++)
            frame[(by + int'($urandom_range(bh - 1, 0))) * IMG_W + bx + int'($urandom_range(bw - 1, 0))] = fg_val();
    endtask

    // Reset, check the cleared outputs, preload the frame, queue the prediction, release.
    task automatic start_run();
        exp_t e;
        key = 4'b0111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", res.done, 0);
        check("rst_empty", res.empty, 0);
        check("rst_geometry", {res.x_min, res.x_max, res.y_min, res.y_max, res.crop_w, res.crop_h}, 0);
        for (int i = 0; i < N_PIX; i++) dut.ram[i] = PIX_W'(frame[i]);
        model_run(e);
        exp_q.push_back(e);
        key       = 4'b1111;
        rel_cycle = cycle;
    endtask

    task automatic wait_done();
        int start_cnt = runs_checked;
        int budget    = RUN_BUDGET;
        while (runs_checked == start_cnt && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("run_completed", runs_checked, start_cnt + 1);
        if (runs_checked == start_cnt && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    // Monitor: every rising done consumes one prediction.
    always @(negedge clk) begin
        if (res.done === 1'b1 && done_prev !== 1'b1) begin
            check("queue_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("empty", res.empty, mon_e.empty);
                check("x_min", res.x_min, mon_e.x0);
                check("x_max", res.x_max, mon_e.x1);
                check("y_min", res.y_min, mon_e.y0);
                check("y_max", res.y_max, mon_e.y1);
                check("crop_w", res.crop_w, mon_e.w);
                check("crop_h", res.crop_h, mon_e.h);
                check("latency", cycle - rel_cycle,
                      mon_e.empty ? N_PIX + 3 : N_PIX + mon_e.w * mon_e.h + 4);
                mon_bad   = 0;
                mon_first = -1;
                for (int i = 0; i < N_PIX; i++)
                    if (crop_known[i] && dut.crop_ram[i] !== PIX_W'(crop_model[i])) begin
                        if (mon_first < 0) mon_first = i;
                        mon_bad++;
                    end
                check("crop_ram_bad_entries", mon_bad, 0);
                if (mon_bad != 0) $display("  first differing crop_ram index %0d", mon_first);
            end
            runs_checked++;
        end
        done_prev = res.done;
    end

    initial begin
        key = 4'b0111;

        fill(BG); frame[7 * IMG_W + 5] = FG_A;
        start_run(); wait_done();

        fill(BG);
        for (int y = 20; y <= 24; y++)
            for (int x = 10; x <= 19; x++) frame[y * IMG_W + x] = FG_B;
        start_run(); wait_done();

        fill(BG);
        start_run(); wait_done();

        fill(BG); frame[0] = FG_B; frame[N_PIX - 1] = FG_B;
        start_run(); wait_done();

        fill(BG); frame[30 * IMG_W + 40] = EDGE_NO;
        start_run(); wait_done();

        frame[30 * IMG_W + 40] = EDGE_YES;
        start_run(); wait_done();

        // Abort in the middle of COPY, then let the restarted run finish.
        fill(BG);
        for (int y = 20; y <= 24; y++)
            for (int x = 10; x <= 19; x++) frame[y * IMG_W + x] = 8 * x + y;
        for (int y = 20; y <= 24; y++) frame[y * IMG_W + 10] = FG_B;
        for (int x = 10; x <= 19; x++) frame[24 * IMG_W + x] = FG_B;
        for (int y = 20; y <= 24; y++) frame[y * IMG_W + 19] = FG_B;
        for (int x = 10; x <= 19; x++) frame[20 * IMG_W + x] = FG_B;
        start_run();
        repeat (N_PIX + 20) @(posedge clk);
        @(negedge clk) key = 4'b0111;
        @(negedge clk);
        check("abort_done", res.done, 0);
        check("abort_geometry", {res.x_min, res.x_max, res.y_min, res.y_max, res.crop_w, res.crop_h}, 0);
        key       = 4'b1111;
        rel_cycle = cycle;
        wait_done();

        for (int t = 0; t < 3; t++) begin
            gen_random();
            start_run(); wait_done();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/image_cropping.md
Name: image_cropping

Overview:
- Self-starting image crop engine.
- Holds a grayscale frame in an internal RAM and raster-scans it to find the bounding box of foreground pixels.
- Copies the boxed region, compacted row-major, into an internal crop RAM and then raises done.
- Sits behind the board-level top; the frame is preloaded into the RAM (simulation: hex file into array ram).

Parameters:
- IMG_W, 64, frame width in pixels.
- IMG_H, 64, frame height in pixels.
- PIX_W, 8, bits per pixel.
- THRESH, 128, foreground threshold.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- KEY  input  4  KEY[3] = reset, synchronous, active-low; KEY[2:0] unused.
- done  output  1  high when crop is complete; held until reset.
- empty  output  1  high with done when no foreground pixel exists.
- x_min, x_max  output  clog2(IMG_W)  bounding-box columns, inclusive.
- y_min, y_max  output  clog2(IMG_H)  bounding-box rows, inclusive.
- crop_w  output  clog2(IMG_W)+1  cropped width.
- crop_h  output  clog2(IMG_H)+1  cropped height.

Behaviour:
- Memories:
  - ram: IMG_W*IMG_H words of PIX_W bits, address = y*IMG_W + x, read-only to the FSM.
  - crop_ram: same depth and width.
  - Both use synchronous read with 1-cycle latency; hierarchical array name for ram is exactly "ram".
- Reset (KEY[3]==0 at a clock edge):
  - state=SCAN_INIT, done=0, empty=0, all coordinate and size outputs 0.
  - ram contents are untouched.
- Reset mid-operation aborts the run; the run restarts from pixel 0 after release.
- No start input; processing begins on the first edge with KEY[3]==1.
- Foreground test: pixel > THRESH (strict).
- States:
  - SCAN_INIT: internal min registers to max value, max registers to 0, found=0, x=y=0; go to SCAN.
  - SCAN: issue one read per cycle in raster order. A pipelined compare one cycle later updates x_min=min, x_max=max, y_min=min, y_max=max and sets found. After the last address (IMG_W*IMG_H-1) plus one flush cycle, go to SCAN_END.
  - SCAN_END: if found=0, set empty=1, all coords 0, crop_w=crop_h=0, go to DONE. Otherwise crop_w=x_max-x_min+1, crop_h=y_max-y_min+1, go to COPY.
  - COPY: read ram[(y_min+r)*IMG_W + x_min+c] for r in 0..crop_h-1, c in 0..crop_w-1. Write the value one cycle later to crop_ram[r*crop_w + c]. One pixel per cycle plus one flush cycle, then go to DONE.
  - DONE: done=1; stays here until reset.
- crop_ram entries at or beyond crop_w*crop_h keep prior contents.
- Latency:
  - Scan = IMG_W*IMG_H + 2 cycles.
  - Copy = crop_w*crop_h + 1 cycles.
  - Total from reset release to done ≈ IMG_W*IMG_H + crop_w*crop_h + 4 cycles.
- Coordinate outputs are valid from SCAN_END onward and stable in DONE.
- Arithmetic is unsigned. Copy address arithmetic uses clog2(IMG_W*IMG_H) bits; no overflow is possible because the box lies inside the frame.

Optional Feature:
- CROP_INVERT_EN defined: foreground test becomes pixel < THRESH (dark object on light background).
- Undefined: pixel > THRESH.
- All other behaviour is identical.

Decomposition:
- Package image_cropping_pkg holds:
  - state enum (SCAN_INIT, SCAN, SCAN_END, COPY, DONE);
  - localparam helpers for address/coordinate widths;
  - a pixel typedef.
- One sub-module is natural: bbox_tracker, which takes a pixel, its x/y, a valid bit and a clear pulse, and produces min/max x/y plus found.

Test Plan:
- Frame all zeros except ram[7*64+5]=200 -> done, empty=0, x_min=x_max=5, y_min=y_max=7, crop_w=crop_h=1, crop_ram[0]=200.
- Rectangle of 255 at x 10..19, y 20..24 -> bbox (10,19,20,24), crop_w=10, crop_h=5, crop_ram[0..49]=255.
- All-zero frame -> done=1, empty=1, all coords and sizes 0, crop_ram unchanged.
- Pixels of 255 at (0,0) and (63,63) -> bbox (0,63,0,63), crop_w=crop_h=64, crop_ram equals ram.
- Threshold edge: pixel value 128 -> not foreground (empty=1); value 129 -> foreground.
- KEY[3] pulsed low during COPY -> done drops to 0, run restarts, and final outputs match a clean run.
